// File: rtl/boid_fb_pkg.sv
// Shared types for the boid frame-buffer scheduler: FSM states and bank indices.
package boid_fb_pkg;

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    CLEAR      = 2'd1,
    DRAW       = 2'd2,
    SWAP       = 2'd3
  } state_t;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address counter for bank clear sweeps: steps 0..DEPTH-1 while run is high,
// flags done on the last address and wraps to 0.
module fb_clear_sweeper #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  assign done = run && (addr == LAST_ADDR);

  // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (start || done) begin
      addr <= '0;
    end else if (run) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/boid_fb_scheduler.sv
// Double-buffered boid occupancy scheduler: bank roles, clear sweeps, pixel writes, display mux.
// Optional per-frame write statistics are built when FRAME_STATS_EN is defined.
module boid_fb_scheduler
  import boid_fb_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   swap_req,
  input  logic                   wr_valid,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   wr_ready,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_data,
  output logic                   ram0_we,
  output logic [ADDR_WIDTH-1:0]  ram0_addr,
  output logic                   ram0_din,
  input  logic                   ram0_dout,
  output logic                   ram1_we,
  output logic [ADDR_WIDTH-1:0]  ram1_addr,
  output logic                   ram1_din,
  input  logic                   ram1_dout,
  output logic                   front_bank,
  output logic                   busy,
  output logic                   overrun,
  output logic [COUNT_WIDTH-1:0] last_frame_writes
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state, state_next;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] sweep;
  logic                  sweep_done;
  logic                  sweep_run;
  logic                  sweep_start;
  logic                  back;
  logic                  accept;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  front_we;
  logic                  rd_ok, rd_ok_q;
  logic                  rd_sel_q;
  logic                  swap_enter;
  logic                  late_swap;

  logic [1:0]            we_q, we_n;
  logic [1:0]            din_q, din_n;
  logic [ADDR_WIDTH-1:0] waddr_q [2];
  logic [ADDR_WIDTH-1:0] waddr_n [2];

  assign back        = ~front_bank;
  assign sweep_run   = (state == INIT_CLEAR) || (state == CLEAR);
  assign sweep_start = (state == SWAP);
  assign accept      = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign late_swap   = swap_req && (state != DRAW);

  fb_clear_sweeper #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweeper (
    .clk   (clk),
    .reset (reset),
    .start (sweep_start),
    .run   (sweep_run),
    .addr  (sweep),
    .done  (sweep_done)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      INIT_CLEAR, CLEAR: begin
        if (sweep_done) state_next = DRAW;
      end
      DRAW: begin
        busy     = 1'b0;
        wr_ready = !pending;
        if (pending || swap_req) state_next = SWAP;
      end
      SWAP:    state_next = CLEAR;
      default: state_next = INIT_CLEAR;
    endcase
  end

  assign swap_enter = (state == DRAW) && (state_next == SWAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT_CLEAR;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      front_bank <= BANK0;
    end else begin
      state <= state_next;
      if (swap_enter) begin
        pending <= 1'b0;
      end else if (late_swap) begin
        pending <= 1'b1;
      end
      if (late_swap) overrun <= 1'b1;
      if (state == SWAP) front_bank <= ~front_bank;
    end
  end

  // Both banks are swept during INIT_CLEAR; afterwards only the back bank is ever written.
  always_comb begin
    we_n       = '0;
    din_n      = '0;
    waddr_n[0] = waddr_q[0];
    waddr_n[1] = waddr_q[1];
    case (state)
      INIT_CLEAR: begin
        we_n       = 2'b11;
        waddr_n[0] = sweep;
        waddr_n[1] = sweep;
      end
      CLEAR: begin
        we_n[back]    = 1'b1;
        waddr_n[back] = sweep;
      end
      DRAW: begin
        if (accept && wr_in_range) begin
          we_n[back]    = 1'b1;
          din_n[back]   = 1'b1;
          waddr_n[back] = wr_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= '0;
      din_q      <= '0;
      waddr_q[0] <= '0;
      waddr_q[1] <= '0;
    end else begin
      we_q       <= we_n;
      din_q      <= din_n;
      waddr_q[0] <= waddr_n[0];
      waddr_q[1] <= waddr_n[1];
    end
  end

  assign ram0_we   = we_q[BANK0];
  assign ram0_din  = din_q[BANK0];
  assign ram0_addr = (front_bank == BANK0 && !we_q[BANK0]) ? rd_addr : waddr_q[BANK0];
  assign ram1_we   = we_q[BANK1];
  assign ram1_din  = din_q[BANK1];
  assign ram1_addr = (front_bank == BANK1 && !we_q[BANK1]) ? rd_addr : waddr_q[BANK1];

  // A read is only valid if the front port actually carried rd_addr in the issuing cycle.
  assign front_we = (front_bank == BANK1) ? we_q[BANK1] : we_q[BANK0];
  assign rd_ok    = (state != INIT_CLEAR) && !front_we && rd_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sel_q <= BANK0;
      rd_ok_q  <= 1'b0;
    end else begin
      rd_sel_q <= front_bank;
      rd_ok_q  <= rd_ok;
    end
  end

  assign rd_data = (state != INIT_CLEAR) && rd_ok_q &&
                   ((rd_sel_q == BANK1) ? ram1_dout : ram0_dout);

`ifdef FRAME_STATS_EN
  logic [COUNT_WIDTH-1:0] frame_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count       <= '0;
      last_frame_writes <= '0;
    end else if (state == SWAP) begin
      last_frame_writes <= frame_count;
      frame_count       <= '0;
    end else if (accept && (frame_count != '1)) begin
      frame_count <= frame_count + 1'b1;
    end
  end
`else
  assign last_frame_writes = '0;
`endif

endmodule
